// File: rtl/debounce_toggle_gen.sv
// Push-button synchronizer/debouncer that emits one T pulse per accepted press.
// Optional auto-repeat while held is enabled by defining DEBOUNCE_TOGGLE_AUTO_REPEAT_EN.
module debounce_toggle_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       en,
  output logic       btn_state,
  output logic       t_out,
  output logic [7:0] pulse_cnt
);

  if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db_cycles
    $error("debounce_toggle_gen: DB_CYCLES must be in 1..65535");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debounce_toggle_gen: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  localparam int DW = $clog2(DB_CYCLES + 1);
  // Flip on the cycle the count would reach DB_CYCLES.
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_L  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RELOAD_L = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_ONE      = RW'(1);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    HELD   = 2'd2
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
    ,REPEAT = 2'd3
`endif
  } state_t;

  logic          s1_q, s1_d, s2_q, s2_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          btn_state_q, btn_state_d;
  logic          btn_prev_q, btn_prev_d;
  state_t        state_q, state_d;
  logic          t_out_q, t_out_d;
  logic [7:0]    pulse_cnt_q, pulse_cnt_d;
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  always_comb begin
    s1_d        = btn_in;
    s2_d        = s1_q;
    db_cnt_d    = '0;
    btn_state_d = btn_state_q;
    if (s2_q != btn_state_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_state_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    btn_prev_d  = btn_state_q;
    pulse_cnt_d = pulse_cnt_q + {7'd0, t_out_q};
  end

  always_comb begin
    state_d = state_q;
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_state_q && !btn_prev_q) state_d = PRESS;
      end
      PRESS: begin
        state_d = btn_state_q ? HELD : IDLE;
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
        rpt_cnt_d = btn_state_q ? RPT_DELAY_L : '0;
`endif
      end
      HELD: begin
        if (!btn_state_q) begin
          state_d = IDLE;
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RPT_ONE) begin
          state_d = REPEAT;
        end else begin
          rpt_cnt_d = rpt_cnt_q - 1'b1;
`endif
        end
      end
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
      REPEAT: begin
        if (!btn_state_q) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (REPEAT_PERIOD == 1) begin
          state_d = REPEAT;
        end else begin
          // The REPEAT cycle itself is the first cycle of the period.
          state_d   = HELD;
          rpt_cnt_d = RPT_RELOAD_L;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
    t_out_d = en && ((state_d == PRESS) || (state_d == REPEAT));
`else
    t_out_d = en && (state_d == PRESS);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      db_cnt_q    <= '0;
      btn_state_q <= 1'b0;
      btn_prev_q  <= 1'b0;
      state_q     <= IDLE;
      t_out_q     <= 1'b0;
      pulse_cnt_q <= 8'd0;
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
      rpt_cnt_q   <= '0;
`endif
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      db_cnt_q    <= db_cnt_d;
      btn_state_q <= btn_state_d;
      btn_prev_q  <= btn_prev_d;
      state_q     <= state_d;
      t_out_q     <= t_out_d;
      pulse_cnt_q <= pulse_cnt_d;
`ifdef DEBOUNCE_TOGGLE_AUTO_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
`endif
    end
  end

  assign btn_state = btn_state_q;
  assign t_out     = t_out_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
